// File: rtl/imm_encode.sv
// -----------------------------------------------------------------------------
// imm_encode
//
// Merges an immediate into a RISC-V instruction template. The immediate is
// placed in the bit positions of the selected format (I, S, B, U, J or shamt),
// and every other bit is taken from base_inst. The LI selector expands a
// 32-bit constant into a LUI/ADDI pair and emits it as one or two beats.
// Results go through a single output register with a valid/ready handshake.
//
// Ports
//   clk        in   1   clock, all state updates on the rising edge
//   rst        in   1   synchronous active-high reset
//   in_valid   in   1   request valid
//   in_ready   out  1   request accepted on in_valid & in_ready
//   imm_in     in   32  immediate (two's complement, unsigned for shamt)
//   imm_sel    in   3   000 I, 001 S, 010 B, 011 U, 100 J, 101 shamt,
//                       110 LI, 111 reserved
//   base_inst  in   32  instruction template (LI uses only [11:7] as rd)
//   out_valid  out  1   inst_out valid
//   out_ready  in   1   consumer accepts on out_valid & out_ready
//   inst_out   out  32  encoded instruction word
//   range_err  out  1   immediate not representable in the selected format
//
// Configuration
//   IMM_ENCODE_RANGE_CHECK_EN  defined: range checks drive range_err.
//                              undefined: range_err is always 0 and no check
//                              logic is built.
// -----------------------------------------------------------------------------
module imm_encode (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] imm_in,
    input  logic [2:0]  imm_sel,
    input  logic [31:0] base_inst,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] inst_out,
    output logic        range_err
);

    typedef enum logic [2:0] {
        SEL_I     = 3'b000,
        SEL_S     = 3'b001,
        SEL_B     = 3'b010,
        SEL_U     = 3'b011,
        SEL_J     = 3'b100,
        SEL_SHAMT = 3'b101,
        SEL_LI    = 3'b110,
        SEL_RSVD  = 3'b111
    } sel_e;

    // LUI   : a two-beat LI has its LUI beat in the output register.
    // ADDI  : the final LI beat (ADDI, or a lone LUI/ADDI) is in the output
    //         register; new requests stay blocked until it is taken.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LUI  = 2'd1,
        ADDI = 2'd2
    } state_e;

    localparam logic [6:0] OPC_LUI = 7'b0110111;
    localparam logic [6:0] OPC_OPI = 7'b0010011;

    state_e      state_q, state_d;
    logic        out_valid_d;
    logic [31:0] inst_d;
    logic        err_d;
    logic [31:0] addi_q, addi_d;

    logic        in_fire;
    logic        out_fire;

    logic [31:0] enc_word;
    logic        enc_err;

    logic [19:0] li_hi;
    logic [11:0] li_lo;
    logic [4:0]  li_rd;
    logic [31:0] lui_word;
    logic [31:0] addi_x0_word;
    logic [31:0] addi_rd_word;
    logic        li_two_beat;
    logic [31:0] li_first;

    // -------------------------------------------------------------------------
    // Format placement and range checking
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path through the case leaves it unassigned (which would infer a
        // latch).
        enc_word = base_inst;
        enc_err  = 1'b0;

        case (imm_sel)
            SEL_I:     enc_word = {imm_in[11:0], base_inst[19:0]};
            SEL_S:     enc_word = {imm_in[11:5], base_inst[24:12],
                                   imm_in[4:0], base_inst[6:0]};
            SEL_B:     enc_word = {imm_in[12], imm_in[10:5], base_inst[24:12],
                                   imm_in[4:1], imm_in[11], base_inst[6:0]};
            SEL_U:     enc_word = {imm_in[31:12], base_inst[11:0]};
            SEL_J:     enc_word = {imm_in[20], imm_in[10:1], imm_in[11],
                                   imm_in[19:12], base_inst[11:0]};
            SEL_SHAMT: enc_word = {base_inst[31:25], imm_in[4:0], base_inst[19:0]};
            default:   enc_word = base_inst;  // LI is built separately; reserved passes through
        endcase

`ifdef IMM_ENCODE_RANGE_CHECK_EN
        // A signed value fits in N bits when all bits from N-1 upward agree.
        case (imm_sel)
            SEL_I, SEL_S: enc_err = !((&imm_in[31:11]) || !(|imm_in[31:11]));
            SEL_B:        enc_err = imm_in[0] || !((&imm_in[31:12]) || !(|imm_in[31:12]));
            SEL_J:        enc_err = imm_in[0] || !((&imm_in[31:20]) || !(|imm_in[31:20]));
            SEL_U:        enc_err = |imm_in[11:0];
            SEL_SHAMT:    enc_err = |imm_in[31:5];
            SEL_RSVD:     enc_err = 1'b1;
            default:      enc_err = 1'b0;
        endcase
`endif
    end

    // -------------------------------------------------------------------------
    // LI expansion. ADDI sign-extends its 12-bit operand, so the upper part is
    // rounded up whenever lo is negative; the sum wraps modulo 2^20.
    // -------------------------------------------------------------------------
    assign li_hi        = imm_in[31:12] + {19'd0, imm_in[11]};
    assign li_lo        = imm_in[11:0];
    assign li_rd        = base_inst[11:7];
    assign lui_word     = {li_hi, li_rd, OPC_LUI};
    assign addi_x0_word = {li_lo, 5'd0, 3'b000, li_rd, OPC_OPI};
    assign addi_rd_word = {li_lo, li_rd, 3'b000, li_rd, OPC_OPI};
    assign li_two_beat  = (li_hi != 20'd0) && (li_lo != 12'd0);
    assign li_first     = (li_hi == 20'd0) ? addi_x0_word : lui_word;

    // -------------------------------------------------------------------------
    // Handshake and sequencing
    // -------------------------------------------------------------------------
    assign in_ready = !rst && (state_q == IDLE) && (!out_valid || out_ready);
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid;
        inst_d      = inst_out;
        err_d       = range_err;
        addi_d      = addi_q;

        unique case (state_q)
            IDLE: begin
                if (in_fire) begin
                    out_valid_d = 1'b1;
                    if (imm_sel == SEL_LI) begin
                        inst_d  = li_first;
                        err_d   = 1'b0;
                        addi_d  = addi_rd_word;
                        state_d = li_two_beat ? LUI : ADDI;
                    end else begin
                        inst_d  = enc_word;
                        err_d   = enc_err;
                    end
                end else if (out_fire) begin
                    out_valid_d = 1'b0;
                end
            end
            LUI: begin
                if (out_fire) begin
                    inst_d  = addi_q;
                    err_d   = 1'b0;
                    state_d = ADDI;
                end
            end
            ADDI: begin
                if (out_fire) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: registers are written with non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            out_valid <= 1'b0;
            inst_out  <= 32'd0;
            range_err <= 1'b0;
            addi_q    <= 32'd0;
        end else begin
            state_q   <= state_d;
            out_valid <= out_valid_d;
            inst_out  <= inst_d;
            range_err <= err_d;
            addi_q    <= addi_d;
        end
    end

endmodule

// File: tb/tb_imm_encode.sv
// -----------------------------------------------------------------------------
// tb_imm_encode
//
// Directed scenario tasks plus a randomized run. A monitor on the falling
// clock edge compares every output against a beat queue filled by a
// behavioural model of the encoder.
// -----------------------------------------------------------------------------
module tb_imm_encode;

`ifdef IMM_ENCODE_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] imm_in;
    logic [2:0]  imm_sel;
    logic [31:0] base_inst;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] inst_out;
    logic        range_err;

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 1'b0;

    typedef struct {
        logic [31:0] word;
        logic        err;
        bit          li;
    } beat_t;

    beat_t mq[$];

    logic [31:0] bnd [19] = '{
        32'hFFFFF800, 32'h000007FF, 32'h00000800, 32'hFFFFF7FF, 32'hFFFFF000,
        32'h00000FFE, 32'h00000FFF, 32'h00001000, 32'hFFFFEFFF, 32'hFFF00000,
        32'h000FFFFE, 32'h00100000, 32'h0000001F, 32'h00000020, 32'h00000000,
        32'h12345FFF, 32'h7FFFF800, 32'hFFFFF001, 32'h80000000
    };

    imm_encode dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .imm_in    (imm_in),
        .imm_sel   (imm_sel),
        .base_inst (base_inst),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .inst_out  (inst_out),
        .range_err (range_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural reference: expected beats for one request.
    task automatic ref_model(input logic [2:0] sel, input logic [31:0] imm,
                             input logic [31:0] base, output int n,
                             output logic [31:0] w0, output logic e0,
                             output logic [31:0] w1);
        int signed   v;
        logic [31:0] hi, lo, rd;
        v  = $signed(imm);
        n  = 1;
        e0 = 1'b0;
        w1 = 32'd0;
        case (sel)
            3'd0: begin
                w0 = {imm[11:0], base[19:0]};
                e0 = RC && (v < -2048 || v > 2047);
            end
            3'd1: begin
                w0 = {imm[11:5], base[24:12], imm[4:0], base[6:0]};
                e0 = RC && (v < -2048 || v > 2047);
            end
            3'd2: begin
                w0 = {imm[12], imm[10:5], base[24:12], imm[4:1], imm[11], base[6:0]};
                e0 = RC && ((v % 2) != 0 || v < -4096 || v > 4094);
            end
            3'd3: begin
                w0 = {imm[31:12], base[11:0]};
                e0 = RC && ((imm % 4096) != 0);
            end
            3'd4: begin
                w0 = {imm[20], imm[10:1], imm[11], imm[19:12], base[11:0]};
                e0 = RC && ((v % 2) != 0 || v < -1048576 || v > 1048574);
            end
            3'd5: begin
                w0 = {base[31:25], imm[4:0], base[19:0]};
                e0 = RC && (imm > 31);
            end
            3'd6: begin
                hi = ((imm >> 12) + ((imm >> 11) & 1)) & 32'h000FFFFF;
                lo = imm & 32'h00000FFF;
                rd = (base >> 7) & 32'h1F;
                if (hi == 0) begin
                    w0 = (lo << 20) | (rd << 7) | 32'h13;
                end else if (lo == 0) begin
                    w0 = (hi << 12) | (rd << 7) | 32'h37;
                end else begin
                    n  = 2;
                    w0 = (hi << 12) | (rd << 7) | 32'h37;
                    w1 = (lo << 20) | (rd << 15) | (rd << 7) | 32'h13;
                end
            end
            default: begin
                w0 = base;
                e0 = RC;
            end
        endcase
    endtask

    // Continuous monitor: outputs and in_ready against the model queue.
    logic [31:0] m_w0, m_w1;
    logic        m_e0;
    int          m_n;
    bit          m_valid, m_ready;
    beat_t       m_beat;

    always @(negedge clk) begin
        if (mon_en) begin
            m_valid = (mq.size() > 0);
            m_ready = !rst && (mq.size() == 0 || (!mq[0].li && out_ready));
            n_checks++;
            if (out_valid !== m_valid) begin
                n_fail++;
                $display("FAIL mon_out_valid @%0t: got %b expected %b", $time, out_valid, m_valid);
            end
            n_checks++;
            if (in_ready !== m_ready) begin
                n_fail++;
                $display("FAIL mon_in_ready @%0t: got %b expected %b", $time, in_ready, m_ready);
            end
            if (m_valid) begin
                n_checks++;
                if (inst_out !== mq[0].word || range_err !== mq[0].err) begin
                    n_fail++;
                    $display("FAIL mon_beat @%0t: got %h/%b expected %h/%b", $time,
                             inst_out, range_err, mq[0].word, mq[0].err);
                end
            end
            if (rst) begin
                mq.delete();
            end else begin
                if (m_valid && out_ready) m_beat = mq.pop_front();
                if (in_valid && m_ready) begin
                    ref_model(imm_sel, imm_in, base_inst, m_n, m_w0, m_e0, m_w1);
                    mq.push_back('{word: m_w0, err: m_e0, li: (imm_sel == 3'd6)});
                    if (m_n == 2) mq.push_back('{word: m_w1, err: 1'b0, li: 1'b1});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request for one edge, then drop in_valid.
    task automatic send(input logic [2:0] sel, input logic [31:0] imm, input logic [31:0] base);
        in_valid  = 1'b1;
        imm_sel   = sel;
        imm_in    = imm;
        base_inst = base;
        tick();
        in_valid  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        out_ready = 1'b1;
        tick();
        mon_en = 1'b1;
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
        n_checks++;
        if (inst_out !== 32'd0) begin n_fail++; $display("FAIL rst_inst_out: got %h expected 00000000", inst_out); end
        n_checks++;
        if (range_err !== 1'b0) begin n_fail++; $display("FAIL rst_range_err: got %b expected 0", range_err); end
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready_during: got %b expected 0", in_ready); end
        rst = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready_after: got %b expected 1", in_ready); end
    endtask

    task automatic test_i_type();
        out_ready = 1'b1;
        send(3'd0, 32'hFFFFFFFF, 32'h00000013);
        n_checks++;
        if (out_valid !== 1'b1 || inst_out !== 32'hFFF00013 || range_err !== 1'b0) begin
            n_fail++;
            $display("FAIL i_type: got v=%b %h/%b expected v=1 fff00013/0", out_valid, inst_out, range_err);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL i_type_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_b_type();
        out_ready = 1'b1;
        send(3'd2, 32'hFFFFFFFC, 32'h00000063);
        n_checks++;
        if (inst_out !== 32'hFE000EE3 || range_err !== 1'b0) begin
            n_fail++;
            $display("FAIL b_type_neg4: got %h/%b expected fe000ee3/0", inst_out, range_err);
        end
        send(3'd2, 32'h00000003, 32'h00000063);
        n_checks++;
        if (inst_out !== 32'h00000163 || range_err !== RC) begin
            n_fail++;
            $display("FAIL b_type_odd: got %h/%b expected 00000163/%b", inst_out, range_err, RC);
        end
        tick();
    endtask

    task automatic test_range_edges();
        out_ready = 1'b1;
        send(3'd0, 32'h000007FF, 32'h00000013);
        n_checks++;
        if (inst_out !== 32'h7FF00013 || range_err !== 1'b0) begin
            n_fail++; $display("FAIL i_2047: got %h/%b expected 7ff00013/0", inst_out, range_err);
        end
        send(3'd0, 32'h00000800, 32'h00000013);
        n_checks++;
        if (inst_out !== 32'h80000013 || range_err !== RC) begin
            n_fail++; $display("FAIL i_2048: got %h/%b expected 80000013/%b", inst_out, range_err, RC);
        end
        send(3'd3, 32'h12345001, 32'h00000037);
        n_checks++;
        if (inst_out !== 32'h12345037 || range_err !== RC) begin
            n_fail++; $display("FAIL u_low_bits: got %h/%b expected 12345037/%b", inst_out, range_err, RC);
        end
        send(3'd5, 32'h00000020, 32'h40005013);
        n_checks++;
        if (inst_out !== 32'h40005013 || range_err !== RC) begin
            n_fail++; $display("FAIL shamt_32: got %h/%b expected 40005013/%b", inst_out, range_err, RC);
        end
        send(3'd7, 32'h00000001, 32'hDEADBEEF);
        n_checks++;
        if (inst_out !== 32'hDEADBEEF || range_err !== RC) begin
            n_fail++; $display("FAIL reserved: got %h/%b expected deadbeef/%b", inst_out, range_err, RC);
        end
        tick();
    endtask

    task automatic test_li();
        out_ready = 1'b1;
        send(3'd6, 32'h12345FFF, 32'h00000280);
        n_checks++;
        if (inst_out !== 32'h123462B7 || range_err !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL li_beat1: got %h/%b rdy=%b expected 123462b7/0 rdy=0", inst_out, range_err, in_ready);
        end
        tick();
        n_checks++;
        if (inst_out !== 32'hFFF28293 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL li_beat2: got %h v=%b rdy=%b expected fff28293 v=1 rdy=0", inst_out, out_valid, in_ready);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL li_done: got v=%b rdy=%b expected v=0 rdy=1", out_valid, in_ready);
        end
    endtask

    task automatic test_li_edges();
        logic [31:0] imms [4] = '{32'h00001000, 32'h000007FF, 32'hFFFFF800, 32'h00000000};
        logic [31:0] exps [4] = '{32'h000012B7, 32'h7FF00293, 32'h80000293, 32'h00000293};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(3'd6, imms[i], 32'h00000280);
            n_checks++;
            if (inst_out !== exps[i] || out_valid !== 1'b1) begin
                n_fail++; $display("FAIL li_edge_%0d: got %h expected %h", i, inst_out, exps[i]);
            end
            tick();
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++; $display("FAIL li_edge_single_%0d: got out_valid %b expected 0", i, out_valid);
            end
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send(3'd6, 32'h12345FFF, 32'h00000280);
        in_valid  = 1'b1;
        imm_sel   = 3'd0;
        imm_in    = 32'h00000001;
        base_inst = 32'h00000013;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (inst_out !== 32'h123462B7 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold_%0d: got %h v=%b rdy=%b expected 123462b7 v=1 rdy=0", i, inst_out, out_valid, in_ready);
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        n_checks++;
        if (inst_out !== 32'hFFF28293 || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL bp_beat2: got %h v=%b expected fff28293 v=1", inst_out, out_valid);
        end
        tick();
    endtask

    task automatic test_reset_mid_li();
        out_ready = 1'b1;
        send(3'd6, 32'h12345FFF, 32'h00000280);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || inst_out !== 32'd0) begin
            n_fail++; $display("FAIL rst_mid_li: got v=%b %h expected v=0 00000000", out_valid, inst_out);
        end
        send(3'd0, 32'h00000005, 32'h00000013);
        n_checks++;
        if (inst_out !== 32'h00500013 || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid_li_next: got %h v=%b expected 00500013 v=1", inst_out, out_valid);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int          n;
        logic [31:0] w0, w1;
        logic        e0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid  = 1'b1;
            imm_sel   = 3'($urandom_range(0, 5));
            imm_in    = $urandom;
            base_inst = $urandom;
            ref_model(imm_sel, imm_in, base_inst, n, w0, e0, w1);
            n_checks++;
            if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_%0d: got %b expected 1", i, in_ready); end
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || inst_out !== w0 || range_err !== e0) begin
                n_fail++; $display("FAIL b2b_beat_%0d: got %h/%b expected %h/%b", i, inst_out, range_err, w0, e0);
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 149) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = ($urandom_range(0, 2) != 0);
            imm_sel   = 3'($urandom_range(0, 7));
            base_inst = $urandom;
            case ($urandom_range(0, 4))
                0: imm_in = $urandom;
                1: imm_in = 32'($urandom_range(0, 127)) - 32'd64;
                2: imm_in = bnd[$urandom_range(0, 18)];
                3: imm_in = $urandom & 32'hFFFFF000;
                default: imm_in = 32'($urandom_range(0, 40));
            endcase
            tick();
        end
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        imm_sel   = 3'd0;
        imm_in    = 32'd0;
        base_inst = 32'd0;
        test_reset();
        test_i_type();
        test_b_type();
        test_range_edges();
        test_li();
        test_li_edges();
        test_backpressure();
        test_reset_mid_li();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imm_encode.md
IMM_ENCODE -- requirements
Module: imm_encode

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 in_valid  input  1  request valid.
REQ-004 in_ready  output  1  request accepted when in_valid & in_ready on a clk edge.
REQ-005 imm_in  input  32  immediate value, two's complement, or unsigned for shamt.
REQ-006 imm_sel  input  3  000 I, 001 S, 010 B, 011 U, 100 J, 101 shamt, 110 LI (constant materialize), 111 reserved.
REQ-007 base_inst  input  32  instruction template; the block clears immediate bit positions and replaces them; for LI only base_inst[11:7] (rd) is used.
REQ-008 out_valid  output  1  inst_out valid.
REQ-009 out_ready  input  1  consumer accepts when out_valid & out_ready.
REQ-010 inst_out  output  32  encoded instruction word.
REQ-011 range_err  output  1  qualifies inst_out: immediate not representable in the selected format.

Function
REQ-012 Placement: I [31:20]=imm[11:0]; S [31:25]=imm[11:5], [11:7]=imm[4:0]; B [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11]; U [31:12]=imm[31:12]; J [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12]; shamt [24:20]=imm[4:0]. All other bits come from base_inst.
REQ-013 Range rules: I/S -2048..2047; B even, -4096..4094; J even, -1048576..1048574; U imm[11:0]==0; shamt 0..31. Violation sets range_err=1 for that beat; bits are still truncated and emitted.
REQ-014 imm_sel 111 emits base_inst unchanged with range_err=1.
REQ-015 Latency: one output register; a request accepted at edge N gives out_valid=1 after edge N.
REQ-016 Output holds inst_out/range_err stable while out_valid & !out_ready.
REQ-017 in_ready = FSM in IDLE and (!out_valid | out_ready); back-to-back single-beat requests sustain one per cycle.
REQ-018 LI: hi = imm[31:12] + imm[11] (mod 2^20), lo = imm[11:0], rd = base_inst[11:7].
REQ-019 LI FSM IDLE -> LUI -> ADDI -> IDLE: beat 1 LUI rd,hi (opcode 0110111); beat 2 ADDI rd,rd,lo (opcode 0010011, funct3 000); advance only on output handshake.
REQ-020 LI with lo==0: emit LUI only. LI with hi==0: emit only ADDI rd,x0,lo. LI with imm==0: single ADDI rd,x0,0.
REQ-021 in_ready=0 from LI acceptance until its last beat is accepted; range_err=0 for all LI beats.
REQ-022 hi wraps mod 2^20 (imm=0xFFFFF800 gives hi=0, emits ADDI only).

Reset
REQ-023 rst=1 at an edge: FSM to IDLE, out_valid=0, inst_out=0, range_err=0, any LI sequence in progress is abandoned.
REQ-024 in_ready=0 during the cycle rst is asserted; in_ready=1 in the first cycle after rst deasserts.

Configuration
REQ-025 Macro IMM_ENCODE_RANGE_CHECK_EN defined: range checks of REQ-013 are active.
REQ-026 Macro undefined: range_err driven 0 in all cases, including imm_sel 111, and no check logic is synthesized; placement and LI behaviour are unchanged.

Verification
REQ-027 I: base 0x00000013, imm -1, sel 000 -> inst_out 0xFFF00013, range_err 0, one cycle later.
REQ-028 B: base 0x00000063, imm -4, sel 010 -> 0xFE000EE3; imm 3 -> range_err 1 when the macro is defined, 0 when undefined.
REQ-029 LI: base rd=5, imm 0x12345FFF -> 0x123462B7 then 0xFFF28293, in_ready 0 until the second beat is accepted.
REQ-030 LI edges: imm 0x00001000 -> single 0x000012B7 (rd=5); imm 0x7FF -> single 0x7FF00293.
REQ-031 Backpressure: out_ready held 0 for 3 cycles mid-LI -> beat 1 held stable, no new request accepted, beat 2 follows the release.
REQ-032 Reset mid-LI after beat 1 -> out_valid 0 next cycle; next request is encoded correctly.
